// File: rtl/shifter_pipe.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROL/ROR) with elastic valid/ready stages.
// Define SHIFTER_PIPE_FLAGS_EN to add registered zero/cout result flags.
module shifter_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  localparam int unsigned LOG   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [LOG-1:0]   shamt,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
`ifdef SHIFTER_PIPE_FLAGS_EN
  ,
  output logic             zero,
  output logic             cout
`endif
);

  localparam int unsigned Last = STAGES - 1;

  localparam logic [2:0] OpSll = 3'b000;
  localparam logic [2:0] OpSrl = 3'b001;
  localparam logic [2:0] OpSra = 3'b011;
  localparam logic [2:0] OpRol = 3'b100;
  localparam logic [2:0] OpRor = 3'b101;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [2:0]       o,
                                                input int unsigned      amt);
    logic [WIDTH-1:0] r;
    case (o)
      OpSll:   r = d << amt;
      OpSrl:   r = d >> amt;
      OpSra:   r = $unsigned($signed(d) >>> amt);
      OpRol:   r = (d << amt) | (d >> (WIDTH - amt));
      OpRor:   r = (d >> amt) | (d << (WIDTH - amt));
      default: r = d;
    endcase
    return r;
  endfunction

  // Applies only the shamt bits whose weight is assigned to this stage.
  function automatic logic [WIDTH-1:0] apply_stage(input logic [WIDTH-1:0] d,
                                                   input logic [LOG-1:0]   s,
                                                   input logic [2:0]       o,
                                                   input int unsigned      stage);
    logic [WIDTH-1:0] r;
    r = d;
    for (int unsigned i = 0; i < LOG; i++) begin
      if (s[i] && ((i * STAGES) / LOG) == stage) begin
        r = shift_by(r, o, 32'd1 << i);
      end
    end
    return r;
  endfunction

`ifdef SHIFTER_PIPE_FLAGS_EN
  // Last bit shifted out is taken from the original operand at entry and carried along.
  function automatic logic cout_of(input logic [WIDTH-1:0] d,
                                   input logic [LOG-1:0]   s,
                                   input logic [2:0]       o);
    logic [2*WIDTH-1:0] t;
    logic               c;
    t = '0;
    c = 1'b0;
    case (o)
      OpSll: begin
        t = {{WIDTH{1'b0}}, d} << s;
        c = t[WIDTH];
      end
      OpSrl, OpSra: begin
        t = {d, {WIDTH{1'b0}}} >> s;
        c = t[WIDTH-1];
      end
      default: c = 1'b0;
    endcase
    return c;
  endfunction
`endif

  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [WIDTH-1:0]  data_d  [STAGES];
  logic [LOG-1:0]    shamt_q [STAGES];
  logic [LOG-1:0]    shamt_d [STAGES];
  logic [2:0]        op_q    [STAGES];
  logic [2:0]        op_d    [STAGES];
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] load;
`ifdef SHIFTER_PIPE_FLAGS_EN
  logic [STAGES-1:0] cout_q, cout_d;
  logic              zero_q, zero_d;
`endif

  // A stage may load if the output drains or any slot at or below it is empty.
  always_comb begin
    logic slot_free;
    load      = '0;
    slot_free = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      slot_free = slot_free | ~valid_q[k];
      load[k]   = slot_free;
    end
  end

  always_comb begin
    logic [WIDTH-1:0] src;
    logic [LOG-1:0]   src_shamt;
    logic [2:0]       src_op;
    logic             src_valid;
    int               p;
`ifdef SHIFTER_PIPE_FLAGS_EN
    logic             src_cout;
    cout_d = cout_q;
    zero_d = zero_q;
`endif
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    for (int k = 0; k < STAGES; k++) begin
      p = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        src       = din;
        src_shamt = shamt;
        src_op    = op;
        src_valid = in_valid;
`ifdef SHIFTER_PIPE_FLAGS_EN
        src_cout  = cout_of(din, shamt, op);
`endif
      end else begin
        src       = data_q[p];
        src_shamt = shamt_q[p];
        src_op    = op_q[p];
        src_valid = valid_q[p];
`ifdef SHIFTER_PIPE_FLAGS_EN
        src_cout  = cout_q[p];
`endif
      end
      if (load[k]) begin
        valid_d[k] = src_valid;
        // Bubbles leave the data registers untouched so held results never glitch.
        if (src_valid) begin
          data_d[k]  = apply_stage(src, src_shamt, src_op, unsigned'(k));
          shamt_d[k] = src_shamt;
          op_d[k]    = src_op;
`ifdef SHIFTER_PIPE_FLAGS_EN
          cout_d[k]  = src_cout;
`endif
        end
      end
    end
`ifdef SHIFTER_PIPE_FLAGS_EN
    if (load[Last] && valid_d[Last]) begin
      zero_d = (data_d[Last] == '0);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
      shamt_q <= '{default: '0};
      op_q    <= '{default: '0};
`ifdef SHIFTER_PIPE_FLAGS_EN
      cout_q  <= '0;
      zero_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
`ifdef SHIFTER_PIPE_FLAGS_EN
      cout_q  <= cout_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[Last];
  assign dout      = data_q[Last];
`ifdef SHIFTER_PIPE_FLAGS_EN
  assign cout      = cout_q[Last];
  assign zero      = zero_q;
`endif

endmodule
